param_issue_queue: RTL and testbench



---
 rtl/param_issue_queue_if.sv | 60 ++++++
 rtl/param_issue_queue.sv | 187 ++++++++++++++++++
 tb/tb_param_issue_queue.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_issue_queue_if.sv
// Dispatch, CDB wakeup and issue signals of the parametrised issue queue.
// The master side drives dispatch/CDB/FU-ready; the slave side is the queue itself.
interface param_issue_queue_if #(
  parameter int PR_SIZE  = 7,
  parameter int FU_NUM   = 3,
  parameter int FU_SIZE  = 2,
  parameter int CDB_NUM  = 2,
  parameter int DATA_W   = 32,
  parameter int ROB_SIZE = 6,
  parameter int CNT_W    = 5
);
  logic                         flush_in;
  logic                         disp_valid_in;
  logic                         disp_ready_out;
  logic [3:0]                   disp_op_in;
  logic [FU_SIZE-1:0]           disp_fu_in;
  logic [PR_SIZE-1:0]           disp_rd_in;
  logic [PR_SIZE-1:0]           disp_rs1_in;
  logic [PR_SIZE-1:0]           disp_rs2_in;
  logic                         disp_rs1_ready_in;
  logic                         disp_rs2_ready_in;
  logic [DATA_W-1:0]            disp_rs1_value_in;
  logic [DATA_W-1:0]            disp_rs2_value_in;
  logic [DATA_W-1:0]            disp_imm_in;
  logic [ROB_SIZE-1:0]          disp_rob_in;
  logic [CDB_NUM-1:0]           cdb_valid_in;
  logic [CDB_NUM*PR_SIZE-1:0]   cdb_tag_in;
  logic [CDB_NUM*DATA_W-1:0]    cdb_value_in;
  logic [FU_NUM-1:0]            fu_ready_in;
  logic [FU_NUM-1:0]            issue_valid_out;
  logic [FU_NUM*4-1:0]          issue_op_out;
  logic [FU_NUM*PR_SIZE-1:0]    issue_rd_out;
  logic [FU_NUM*DATA_W-1:0]     issue_rs1_value_out;
  logic [FU_NUM*DATA_W-1:0]     issue_rs2_value_out;
  logic [FU_NUM*DATA_W-1:0]     issue_imm_out;
  logic [FU_NUM*ROB_SIZE-1:0]   issue_rob_out;
  logic [CNT_W-1:0]             count_out;
  logic                         full_out;
  logic                         empty_out;

  modport master (
    output flush_in, disp_valid_in, disp_op_in, disp_fu_in, disp_rd_in,
           disp_rs1_in, disp_rs2_in, disp_rs1_ready_in, disp_rs2_ready_in,
           disp_rs1_value_in, disp_rs2_value_in, disp_imm_in, disp_rob_in,
           cdb_valid_in, cdb_tag_in, cdb_value_in, fu_ready_in,
    input  disp_ready_out, issue_valid_out, issue_op_out, issue_rd_out,
           issue_rs1_value_out, issue_rs2_value_out, issue_imm_out,
           issue_rob_out, count_out, full_out, empty_out
  );

  modport slave (
    input  flush_in, disp_valid_in, disp_op_in, disp_fu_in, disp_rd_in,
           disp_rs1_in, disp_rs2_in, disp_rs1_ready_in, disp_rs2_ready_in,
           disp_rs1_value_in, disp_rs2_value_in, disp_imm_in, disp_rob_in,
           cdb_valid_in, cdb_tag_in, cdb_value_in, fu_ready_in,
    output disp_ready_out, issue_valid_out, issue_op_out, issue_rd_out,
           issue_rs1_value_out, issue_rs2_value_out, issue_imm_out,
           issue_rob_out, count_out, full_out, empty_out
  );
endinterface

// File: rtl/param_issue_queue.sv
// Unified issue queue: valid/ready dispatch, multi-CDB operand wakeup and
// per-FU oldest-ready select driven by an age matrix.
module param_issue_queue #(
  parameter int RS_SIZE  = 16,
  parameter int PR_SIZE  = 7,
  parameter int FU_NUM   = 3,
  parameter int FU_SIZE  = 2,
  parameter int CDB_NUM  = 2,
  parameter int DATA_W   = 32,
  parameter int ROB_SIZE = 6,
  parameter int CNT_W    = 5
) (
  input logic clk,
  input logic rst,
  param_issue_queue_if.slave iq
);
  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RS_SIZE);

  logic [RS_SIZE-1:0]  valid;
  logic [RS_SIZE-1:0]  older [RS_SIZE];
  logic [CNT_W-1:0]    count;

  logic [3:0]          e_op      [RS_SIZE];
  logic [FU_SIZE-1:0]  e_fu      [RS_SIZE];
  logic [PR_SIZE-1:0]  e_rd      [RS_SIZE];
  logic [PR_SIZE-1:0]  e_rs1_tag [RS_SIZE];
  logic [PR_SIZE-1:0]  e_rs2_tag [RS_SIZE];
  logic [DATA_W-1:0]   e_rs1_val [RS_SIZE];
  logic [DATA_W-1:0]   e_rs2_val [RS_SIZE];
  logic [DATA_W-1:0]   e_imm     [RS_SIZE];
  logic [ROB_SIZE-1:0] e_rob     [RS_SIZE];
  logic [RS_SIZE-1:0]  e_rs1_rdy;
  logic [RS_SIZE-1:0]  e_rs2_rdy;

  logic [CDB_NUM-1:0]         cdb_valid;
  logic [CDB_NUM*PR_SIZE-1:0] cdb_tag;
  logic [CDB_NUM*DATA_W-1:0]  cdb_value;

  logic                disp_ready;
  logic                accept;
  logic [IDX_W-1:0]    free_idx;
  logic [RS_SIZE-1:0]  alloc_mask;
  logic [DATA_W:0]     disp_rs1_w;
  logic [DATA_W:0]     disp_rs2_w;
  logic [DATA_W:0]     e_rs1_w [RS_SIZE];
  logic [DATA_W:0]     e_rs2_w [RS_SIZE];
  logic [RS_SIZE-1:0]  elig [FU_NUM];
  logic [FU_NUM-1:0]   sel_found;
  logic [IDX_W-1:0]    sel_idx [FU_NUM];
  logic [RS_SIZE-1:0]  issued_mask;
  logic [CNT_W-1:0]    issued_cnt;
  logic [CNT_W-1:0]    count_next;
  logic [RS_SIZE-1:0]  valid_next;
  logic [RS_SIZE-1:0]  older_next [RS_SIZE];

  assign cdb_valid = iq.cdb_valid_in;
  assign cdb_tag   = iq.cdb_tag_in;
  assign cdb_value = iq.cdb_value_in;

  assign disp_ready        = (count < FULL_CNT);
  assign iq.disp_ready_out = disp_ready;
  assign iq.count_out      = count;
  assign iq.full_out       = (count == FULL_CNT);
  assign iq.empty_out      = (count == '0);

  // Returns {hit, value}; buses are scanned high to low so the lowest bus wins, tag 0 never hits.
  function automatic logic [DATA_W:0] wake(input logic [PR_SIZE-1:0] tag);
    logic [DATA_W:0] r;
    r = '0;
    for (int b = CDB_NUM - 1; b >= 0; b--) begin
      if (cdb_valid[b] && tag != '0 && cdb_tag[b*PR_SIZE +: PR_SIZE] == tag)
        r = {1'b1, cdb_value[b*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  always_comb begin
    accept     = iq.disp_valid_in && disp_ready && !iq.flush_in;
    free_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--)
      if (!valid[i]) free_idx = IDX_W'(i);
    alloc_mask = '0;
    if (accept) alloc_mask[free_idx] = 1'b1;
    disp_rs1_w = wake(iq.disp_rs1_in);
    disp_rs2_w = wake(iq.disp_rs2_in);
    for (int i = 0; i < RS_SIZE; i++) begin
      e_rs1_w[i] = wake(e_rs1_tag[i]);
      e_rs2_w[i] = wake(e_rs2_tag[i]);
    end
  end

  // An entry is picked for FU f when no other eligible entry for f is older than it.
  always_comb begin
    issued_mask = '0;
    issued_cnt  = '0;
    for (int f = 0; f < FU_NUM; f++) begin
      elig[f]      = '0;
      sel_found[f] = 1'b0;
      sel_idx[f]   = '0;
      for (int i = 0; i < RS_SIZE; i++)
        elig[f][i] = valid[i] && e_rs1_rdy[i] && e_rs2_rdy[i] &&
                     (e_fu[i] == FU_SIZE'(f)) && iq.fu_ready_in[f];
      for (int i = 0; i < RS_SIZE; i++) begin
        if (elig[f][i] && ((elig[f] & older[i]) == '0)) begin
          sel_found[f] = 1'b1;
          sel_idx[f]   = IDX_W'(i);
        end
      end
      if (sel_found[f]) issued_mask[sel_idx[f]] = 1'b1;
    end
    for (int i = 0; i < RS_SIZE; i++)
      issued_cnt = issued_cnt + CNT_W'(issued_mask[i]);
    count_next = count + CNT_W'(accept) - issued_cnt;
    valid_next = (valid & ~issued_mask) | alloc_mask;
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      older_next[i] = issued_mask[i] ? '0 : (older[i] & ~issued_mask);
      if (accept) older_next[i][free_idx] = 1'b0;
    end
    if (accept) older_next[free_idx] = valid & ~issued_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid                  <= '0;
      count                  <= '0;
      for (int i = 0; i < RS_SIZE; i++) older[i] <= '0;
      iq.issue_valid_out     <= '0;
      iq.issue_op_out        <= '0;
      iq.issue_rd_out        <= '0;
      iq.issue_rs1_value_out <= '0;
      iq.issue_rs2_value_out <= '0;
      iq.issue_imm_out       <= '0;
      iq.issue_rob_out       <= '0;
    end else if (iq.flush_in) begin
      valid              <= '0;
      count              <= '0;
      for (int i = 0; i < RS_SIZE; i++) older[i] <= '0;
      iq.issue_valid_out <= '0;
    end else begin
      valid <= valid_next;
      count <= count_next;
      for (int i = 0; i < RS_SIZE; i++) older[i] <= older_next[i];
      for (int f = 0; f < FU_NUM; f++) begin
        iq.issue_valid_out[f] <= sel_found[f];
        if (sel_found[f]) begin
          iq.issue_op_out[f*4 +: 4]                  <= e_op[sel_idx[f]];
          iq.issue_rd_out[f*PR_SIZE +: PR_SIZE]      <= e_rd[sel_idx[f]];
          iq.issue_rs1_value_out[f*DATA_W +: DATA_W] <= e_rs1_val[sel_idx[f]];
          iq.issue_rs2_value_out[f*DATA_W +: DATA_W] <= e_rs2_val[sel_idx[f]];
          iq.issue_imm_out[f*DATA_W +: DATA_W]       <= e_imm[sel_idx[f]];
          iq.issue_rob_out[f*ROB_SIZE +: ROB_SIZE]   <= e_rob[sel_idx[f]];
        end
      end
    end
  end

  // Entry payload needs no reset: it is only observed while its valid bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_SIZE; i++) begin
      if (valid[i] && !e_rs1_rdy[i] && e_rs1_w[i][DATA_W]) begin
        e_rs1_rdy[i] <= 1'b1;
        e_rs1_val[i] <= e_rs1_w[i][DATA_W-1:0];
      end
      if (valid[i] && !e_rs2_rdy[i] && e_rs2_w[i][DATA_W]) begin
        e_rs2_rdy[i] <= 1'b1;
        e_rs2_val[i] <= e_rs2_w[i][DATA_W-1:0];
      end
    end
    if (accept) begin
      e_op[free_idx]      <= iq.disp_op_in;
      e_fu[free_idx]      <= iq.disp_fu_in;
      e_rd[free_idx]      <= iq.disp_rd_in;
      e_rs1_tag[free_idx] <= iq.disp_rs1_in;
      e_rs2_tag[free_idx] <= iq.disp_rs2_in;
      e_imm[free_idx]     <= iq.disp_imm_in;
      e_rob[free_idx]     <= iq.disp_rob_in;
      e_rs1_rdy[free_idx] <= iq.disp_rs1_ready_in || disp_rs1_w[DATA_W];
      e_rs2_rdy[free_idx] <= iq.disp_rs2_ready_in || disp_rs2_w[DATA_W];
      e_rs1_val[free_idx] <= iq.disp_rs1_ready_in ? iq.disp_rs1_value_in : disp_rs1_w[DATA_W-1:0];
      e_rs2_val[free_idx] <= iq.disp_rs2_ready_in ? iq.disp_rs2_value_in : disp_rs2_w[DATA_W-1:0];
    end
  end
endmodule

// File: tb/tb_param_issue_queue.sv
// Directed bench for param_issue_queue: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_param_issue_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  param_issue_queue_if iq ();

  param_issue_queue dut (
    .clk (clk),
    .rst (rst),
    .iq  (iq)
  );

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iq.flush_in          = 1'b0;
    iq.disp_valid_in     = 1'b0;
    iq.disp_op_in        = '0;
    iq.disp_fu_in        = '0;
    iq.disp_rd_in        = '0;
    iq.disp_rs1_in       = '0;
    iq.disp_rs2_in       = '0;
    iq.disp_rs1_ready_in = 1'b0;
    iq.disp_rs2_ready_in = 1'b0;
    iq.disp_rs1_value_in = '0;
    iq.disp_rs2_value_in = '0;
    iq.disp_imm_in       = '0;
    iq.disp_rob_in       = '0;
    iq.cdb_valid_in      = '0;
    iq.cdb_tag_in        = '0;
    iq.cdb_value_in      = '0;
  endtask

  task automatic apply_dispatch(input logic [3:0] op, input logic [1:0] fu, input logic [6:0] rd,
                                input logic r1_rdy, input logic [6:0] r1_tag, input logic [31:0] r1_val,
                                input logic r2_rdy, input logic [6:0] r2_tag, input logic [31:0] r2_val,
                                input logic [5:0] rob);
    iq.disp_valid_in     = 1'b1;
    iq.disp_op_in        = op;
    iq.disp_fu_in        = fu;
    iq.disp_rd_in        = rd;
    iq.disp_rs1_ready_in = r1_rdy;
    iq.disp_rs1_in       = r1_tag;
    iq.disp_rs1_value_in = r1_val;
    iq.disp_rs2_ready_in = r2_rdy;
    iq.disp_rs2_in       = r2_tag;
    iq.disp_rs2_value_in = r2_val;
    iq.disp_imm_in       = {26'd0, rob};
    iq.disp_rob_in       = rob;
  endtask

  function automatic logic [5:0] rob_of(input int f);
    return iq.issue_rob_out[f*6 +: 6];
  endfunction

  function automatic logic [31:0] rs1_of(input int f);
    return iq.issue_rs1_value_out[f*32 +: 32];
  endfunction

  function automatic logic [31:0] rs2_of(input int f);
    return iq.issue_rs2_value_out[f*32 +: 32];
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the directed sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    idle_inputs();
    iq.fu_ready_in = 3'b111;
    tick();
    tick();
    rst = 1'b0;
    check_output("reset_count", iq.count_out, 0);
    check_output("reset_empty", iq.empty_out, 1);
    check_output("reset_full", iq.full_out, 0);
    check_output("reset_ready", iq.disp_ready_out, 1);
    check_output("reset_issue", iq.issue_valid_out, 0);

    // Single ready ADD on FU 0
    apply_dispatch(4'd1, 2'd0, 7'd5, 1'b1, 7'd1, 32'd3, 1'b1, 7'd2, 32'd4, 6'd0);
    tick();
    idle_inputs();
    check_output("add_count_after_accept", iq.count_out, 1);
    check_output("add_no_issue_yet", iq.issue_valid_out, 0);
    tick();
    check_output("add_issue_valid", iq.issue_valid_out, 3'b001);
    check_output("add_op", iq.issue_op_out[3:0], 1);
    check_output("add_rd", iq.issue_rd_out[6:0], 5);
    check_output("add_rs1", rs1_of(0), 3);
    check_output("add_rs2", rs2_of(0), 4);
    check_output("add_count_back", iq.count_out, 0);
    check_output("add_empty_back", iq.empty_out, 1);
    tick();
    check_output("add_strobe_drops", iq.issue_valid_out, 0);
    check_output("add_payload_holds", iq.issue_rd_out[6:0], 5);

    // A waits on tag 9, B is ready; B issues first, then A after bus-1 wakeup
    apply_dispatch(4'd2, 2'd1, 7'd10, 1'b0, 7'd9, 32'd0, 1'b1, 7'd3, 32'd2, 6'd1);
    tick();
    apply_dispatch(4'd3, 2'd1, 7'd11, 1'b1, 7'd4, 32'd7, 1'b1, 7'd6, 32'd8, 6'd2);
    tick();
    idle_inputs();
    check_output("ab_count_two", iq.count_out, 2);
    tick();
    check_output("b_issue_valid", iq.issue_valid_out, 3'b010);
    check_output("b_issue_rob", rob_of(1), 2);
    check_output("ab_count_one", iq.count_out, 1);
    iq.cdb_valid_in = 2'b10;
    iq.cdb_tag_in   = {7'd9, 7'd0};
    iq.cdb_value_in = {32'h55, 32'h0};
    tick();
    idle_inputs();
    check_output("a_not_issued_on_wake_edge", iq.issue_valid_out, 0);
    tick();
    check_output("a_issue_valid", iq.issue_valid_out, 3'b010);
    check_output("a_issue_rob", rob_of(1), 1);
    check_output("a_rs1_woken", rs1_of(1), 32'h55);
    check_output("a_rs2_kept", rs2_of(1), 2);
    check_output("ab_count_zero", iq.count_out, 0);

    // Both buses match tag 20: bus 0 must win
    apply_dispatch(4'd4, 2'd0, 7'd12, 1'b0, 7'd20, 32'd0, 1'b1, 7'd5, 32'd1, 6'd3);
    tick();
    idle_inputs();
    iq.cdb_valid_in = 2'b11;
    iq.cdb_tag_in   = {7'd20, 7'd20};
    iq.cdb_value_in = {32'h22, 32'h11};
    tick();
    idle_inputs();
    tick();
    check_output("bus_prio_issue", iq.issue_valid_out, 3'b001);
    check_output("bus_prio_value", rs1_of(0), 32'h11);

    // Same-cycle CDB capture at dispatch on FU 2
    apply_dispatch(4'd5, 2'd2, 7'd13, 1'b1, 7'd7, 32'd5, 1'b0, 7'd12, 32'd0, 6'd4);
    iq.cdb_valid_in = 2'b01;
    iq.cdb_tag_in   = {7'd0, 7'd12};
    iq.cdb_value_in = {32'h0, 32'hAB};
    tick();
    idle_inputs();
    tick();
    check_output("capture_issue", iq.issue_valid_out, 3'b100);
    check_output("capture_rs2", rs2_of(2), 32'hAB);
    check_output("capture_rob", rob_of(2), 4);

    // Tag-0 broadcast must not wake an rs2 waiting on tag 0
    apply_dispatch(4'd6, 2'd2, 7'd14, 1'b1, 7'd8, 32'd6, 1'b0, 7'd0, 32'd0, 6'd5);
    tick();
    idle_inputs();
    iq.cdb_valid_in = 2'b01;
    iq.cdb_tag_in   = {7'd0, 7'd0};
    iq.cdb_value_in = {32'h0, 32'h99};
    tick();
    idle_inputs();
    check_output("tag0_no_issue_a", iq.issue_valid_out, 0);
    tick();
    check_output("tag0_no_issue_b", iq.issue_valid_out, 0);
    check_output("tag0_still_queued", iq.count_out, 1);
    iq.flush_in = 1'b1;
    tick();
    idle_inputs();
    check_output("tag0_flushed", iq.count_out, 0);

    // Fill all 16 entries with every FU blocked, round-robin FU assignment
    iq.fu_ready_in = 3'b000;
    for (int i = 0; i < 16; i++) begin
      apply_dispatch(4'd7, 2'(i % 3), 7'(i + 1), 1'b1, 7'd0, 32'(i), 1'b1, 7'd0, 32'(i + 100), 6'(i));
      tick();
    end
    check_output("fill_count", iq.count_out, 16);
    check_output("fill_full", iq.full_out, 1);
    check_output("fill_not_ready", iq.disp_ready_out, 0);
    check_output("fill_not_empty", iq.empty_out, 0);
    apply_dispatch(4'd7, 2'd0, 7'd99, 1'b1, 7'd0, 32'd0, 1'b1, 7'd0, 32'd0, 6'd31);
    tick();
    idle_inputs();
    check_output("overflow_rejected", iq.count_out, 16);
    iq.fu_ready_in = 3'b111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_output("drain_valid", iq.issue_valid_out, 3'b111);
      check_output("drain_rob_fu0", rob_of(0), 6'(3 * k));
      check_output("drain_rob_fu1", rob_of(1), 6'(3 * k + 1));
      check_output("drain_rob_fu2", rob_of(2), 6'(3 * k + 2));
      check_output("drain_count", iq.count_out, 5'(13 - 3 * k));
    end
    tick();
    check_output("drain_last_valid", iq.issue_valid_out, 3'b001);
    check_output("drain_last_rob", rob_of(0), 15);
    check_output("drain_last_count", iq.count_out, 0);
    tick();
    check_output("drain_idle", iq.issue_valid_out, 0);

    // Age order on FU 2 across reused slots: robs land in slots 2,3,0,1
    iq.fu_ready_in = 3'b000;
    apply_dispatch(4'd8, 2'd0, 7'd20, 1'b1, 7'd0, 32'd1, 1'b1, 7'd0, 32'd1, 6'd20);
    tick();
    apply_dispatch(4'd8, 2'd1, 7'd21, 1'b1, 7'd0, 32'd1, 1'b1, 7'd0, 32'd1, 6'd21);
    tick();
    apply_dispatch(4'd8, 2'd2, 7'd22, 1'b1, 7'd0, 32'd1, 1'b1, 7'd0, 32'd1, 6'd0);
    tick();
    iq.fu_ready_in = 3'b011;
    apply_dispatch(4'd8, 2'd2, 7'd23, 1'b1, 7'd0, 32'd1, 1'b1, 7'd0, 32'd1, 6'd1);
    tick();
    check_output("age_side_issue", iq.issue_valid_out, 3'b011);
    check_output("age_side_rob0", rob_of(0), 20);
    check_output("age_side_rob1", rob_of(1), 21);
    check_output("age_side_count", iq.count_out, 2);
    apply_dispatch(4'd8, 2'd2, 7'd24, 1'b1, 7'd0, 32'd1, 1'b1, 7'd0, 32'd1, 6'd2);
    tick();
    apply_dispatch(4'd8, 2'd2, 7'd25, 1'b1, 7'd0, 32'd1, 1'b1, 7'd0, 32'd1, 6'd3);
    tick();
    idle_inputs();
    tick();
    check_output("age_blocked", iq.issue_valid_out, 0);
    check_output("age_blocked_count", iq.count_out, 4);
    iq.fu_ready_in = 3'b111;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_output("age_order_valid", iq.issue_valid_out, 3'b100);
      check_output("age_order_rob", rob_of(2), 6'(k));
    end
    check_output("age_order_count", iq.count_out, 0);

    // Flush with 6 waiting entries, a concurrent dispatch and concurrent issue opportunity
    iq.fu_ready_in = 3'b000;
    for (int i = 0; i < 6; i++) begin
      apply_dispatch(4'd9, 2'd0, 7'd30, 1'b1, 7'd0, 32'd1, 1'b1, 7'd0, 32'd1, 6'(40 + i));
      tick();
    end
    check_output("preflush_count", iq.count_out, 6);
    apply_dispatch(4'd9, 2'd0, 7'd31, 1'b1, 7'd0, 32'd1, 1'b1, 7'd0, 32'd1, 6'd46);
    iq.fu_ready_in = 3'b111;
    iq.flush_in    = 1'b1;
    tick();
    idle_inputs();
    check_output("flush_count", iq.count_out, 0);
    check_output("flush_empty", iq.empty_out, 1);
    check_output("flush_issue", iq.issue_valid_out, 0);
    check_output("flush_ready", iq.disp_ready_out, 1);
    tick();
    check_output("postflush_no_issue_a", iq.issue_valid_out, 0);
    tick();
    check_output("postflush_no_issue_b", iq.issue_valid_out, 0);
    check_output("postflush_count", iq.count_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
